// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the Kyber NTT/INTT butterfly scheduler.
// Opcodes, FSM state encoding and default latencies live here.
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_NTT  = 2'b01;
  localparam logic [1:0] OP_INTT = 2'b10;

  localparam int N            = 256;
  localparam int NUM_BF       = 128;
  localparam int NUM_LAYERS   = 7;
  localparam int DEF_RBFU_LAT = 5;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DATA_WIDTH   = 12;

  function automatic logic [1:0] mode_opcode(input logic m);
    if (m) begin
      return OP_INTT;
    end else begin
      return OP_NTT;
    end
  endfunction

endpackage

// File: rtl/ntt_sched_bf_addr_gen.sv
// Combinational butterfly address generator: (mode, layer, bf) -> operand
// addresses and twiddle ROM index for one Cooley-Tukey / Gentleman-Sande step.
module bf_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int TW_W   = 7
) (
  input  logic              mode,
  input  logic [2:0]        layer,
  input  logic [6:0]        bf,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw
);

  logic [3:0] lg_s;
  logic [8:0] len_s;
  logic [8:0] group_s;
  logic [8:0] off_s;
  logic [8:0] j_s;
  logic [8:0] tw_s;

  // lg_s is log2 of the butterfly span; NTT halves it per layer, INTT doubles it
  always_comb begin
    lg_s    = 4'd0;
    len_s   = 9'd0;
    group_s = 9'd0;
    off_s   = 9'd0;
    j_s     = 9'd0;
    tw_s    = 9'd0;
    if (mode) begin
      lg_s = {1'b0, layer} + 4'd1;
    end else begin
      lg_s = 4'd7 - {1'b0, layer};
    end
    len_s   = 9'd1 << lg_s;
    group_s = {2'b00, bf} >> lg_s;
    off_s   = {2'b00, bf} & (len_s - 9'd1);
    j_s     = (group_s << (lg_s + 4'd1)) + off_s;
    if (mode) begin
      tw_s = (9'd128 >> layer) - 9'd1 - group_s;
    end else begin
      tw_s = (9'd1 << layer) + group_s;
    end
    addr_a = ADDR_W'(j_s);
    addr_b = ADDR_W'(j_s + len_s);
    tw     = TW_W'(tw_s);
  end

endmodule

// File: rtl/ntt_sched.sv
// Layer-by-layer NTT/INTT operand scheduler: one butterfly per cycle, a drain
// gap of MEM_LAT+RBFU_LAT cycles between layers, delayed in-place write-back.
module ntt_sched #(
  parameter int RBFU_LAT = 5,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 8,
  parameter int TW_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [1:0]        opcode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);
  import ntt_sched_pkg::*;

  localparam int D  = MEM_LAT + RBFU_LAT;
  localparam int CW = $clog2(D + 1);

  state_t      state_r;
  logic        mode_r;
  logic [2:0]  layer_r;
  logic [7:0]  bf_r;
  logic [CW-1:0] cnt_r;

  logic              gen_mode_s;
  logic [2:0]        gen_layer_s;
  logic [6:0]        gen_bf_s;
  logic [ADDR_W-1:0] gen_a_s;
  logic [ADDR_W-1:0] gen_b_s;
  logic [TW_W-1:0]   gen_tw_s;

  logic [D-1:0]      wr_pipe_r;
  logic [ADDR_W-1:0] a_pipe_r [D];
  logic [ADDR_W-1:0] b_pipe_r [D];

  // Generator looks one butterfly ahead so the read outputs can be registered
  always_comb begin
    gen_mode_s  = mode_r;
    gen_layer_s = layer_r;
    gen_bf_s    = 7'd0;
    case (state_r)
      ST_IDLE:  gen_mode_s  = mode;
      ST_ISSUE: gen_bf_s    = bf_r[6:0];
      ST_DRAIN: gen_layer_s = layer_r + 3'd1;
      default:  gen_bf_s    = 7'd0;
    endcase
  end

  bf_addr_gen #(.ADDR_W(ADDR_W), .TW_W(TW_W)) u_gen (
    .mode   (gen_mode_s),
    .layer  (gen_layer_s),
    .bf     (gen_bf_s),
    .addr_a (gen_a_s),
    .addr_b (gen_b_s),
    .tw     (gen_tw_s)
  );

  // Control FSM; bf_r counts the next butterfly to present on the read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mode_r    <= 1'b0;
      layer_r   <= 3'd0;
      bf_r      <= 8'd0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      opcode    <= OP_NONE;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_ISSUE;
            mode_r    <= mode;
            layer_r   <= 3'd0;
            bf_r      <= 8'd1;
            busy      <= 1'b1;
            opcode    <= mode_opcode(mode);
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a_s;
            rd_addr_b <= gen_b_s;
            tw_addr   <= gen_tw_s;
          end else begin
            rd_en <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (bf_r == 8'd128) begin
            state_r <= ST_DRAIN;
            rd_en   <= 1'b0;
            cnt_r   <= '0;
          end else begin
            bf_r      <= bf_r + 8'd1;
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a_s;
            rd_addr_b <= gen_b_s;
            tw_addr   <= gen_tw_s;
          end
        end
        ST_DRAIN: begin
          if (cnt_r == CW'(D - 1)) begin
            if (layer_r == 3'd6) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r   <= ST_ISSUE;
              layer_r   <= layer_r + 3'd1;
              bf_r      <= 8'd1;
              rd_en     <= 1'b1;
              rd_addr_a <= gen_a_s;
              rd_addr_b <= gen_b_s;
              tw_addr   <= gen_tw_s;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          opcode  <= OP_NONE;
          layer_r <= 3'd0;
          bf_r    <= 8'd0;
          mode_r  <= 1'b0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Write-back delay line; reset flushes in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pipe_r <= '0;
      for (int i = 0; i < D; i++) begin
        a_pipe_r[i] <= '0;
        b_pipe_r[i] <= '0;
      end
    end else begin
      wr_pipe_r[0] <= rd_en;
      a_pipe_r[0]  <= rd_addr_a;
      b_pipe_r[0]  <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        wr_pipe_r[i] <= wr_pipe_r[i-1];
        a_pipe_r[i]  <= a_pipe_r[i-1];
        b_pipe_r[i]  <= b_pipe_r[i-1];
      end
    end
  end

  assign wr_en     = wr_pipe_r[D-1];
  assign wr_addr_a = a_pipe_r[D-1];
  assign wr_addr_b = b_pipe_r[D-1];

endmodule

// File: tb/tb_ntt_sched.sv
// Directed bench for ntt_sched: address vectors, full-run timing,
// ignored start while busy, and reset in the middle of a run.
module tb_ntt_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic [1:0] opcode;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] tw_addr;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  always #5 clk = ~clk;

  ntt_sched #(.RBFU_LAT(5), .MEM_LAT(1), .ADDR_W(8), .TW_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .opcode(opcode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  typedef struct {
    logic m;
    int   layer;
    int   bf;
    int   a;
    int   b;
    int   tw;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  int rd_a[896], rd_b[896], rd_tw[896], rd_cyc[896];
  int wr_a[896], wr_b[896], wr_cyc[896];
  int nrd, nwr, ndone, done_cyc, busy_cnt, busy_first, busy_last, op_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_opcode"}, int'(opcode), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_addr_or"}, int'(rd_addr_a | rd_addr_b | wr_addr_a | wr_addr_b), 0);
    chk({tag, "_tw"}, int'(tw_addr), 0);
  endtask

  // Runs one full transform and records every read/write with its cycle number.
  task automatic run(input logic m, input bit poke);
    int exp_op;
    exp_op = m ? 2 : 1;
    nrd = 0; nwr = 0; ndone = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1; op_err = 0;
    for (int k = 0; k < 896; k++) begin
      rd_a[k] = -1; rd_b[k] = -1; rd_tw[k] = -1; rd_cyc[k] = -1;
      wr_a[k] = -1; wr_b[k] = -1; wr_cyc[k] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    for (int cyc = 1; cyc <= 945; cyc++) begin
      if (rd_en) begin
        if (nrd < 896) begin
          rd_a[nrd] = int'(rd_addr_a); rd_b[nrd] = int'(rd_addr_b);
          rd_tw[nrd] = int'(tw_addr);  rd_cyc[nrd] = cyc;
        end
        nrd++;
      end
      if (wr_en) begin
        if (nwr < 896) begin
          wr_a[nwr] = int'(wr_addr_a); wr_b[nwr] = int'(wr_addr_b); wr_cyc[nwr] = cyc;
        end
        nwr++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        busy_cnt++;
        if (int'(opcode) != exp_op) op_err++;
      end
      if (poke && (cyc == 300 || cyc == 301)) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
        mode  = 1'b0;
      end
      @(negedge clk);
    end
    chk("rd_count", nrd, 896);
    chk("wr_count", nwr, 896);
    chk("done_pulses", ndone, 1);
    chk("done_cycle", done_cyc, 939);
    chk("busy_first", busy_first, 1);
    chk("busy_last", busy_last, 938);
    chk("busy_cycles", busy_cnt, 938);
    chk("opcode_err", op_err, 0);
    begin
      int dly_err, gap_err, perm_err;
      bit seen[256];
      dly_err = 0; gap_err = 0; perm_err = 0;
      for (int k = 0; k < 896; k++) begin
        if (wr_cyc[k] != rd_cyc[k] + 6 || wr_a[k] != rd_a[k] || wr_b[k] != rd_b[k])
          dly_err++;
      end
      for (int l = 1; l < 7; l++) begin
        if (rd_cyc[l*128] != wr_cyc[l*128-1] + 1) gap_err++;
      end
      for (int l = 0; l < 7; l++) begin
        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        for (int k = l*128; k < l*128 + 128; k++) begin
          if (rd_a[k] < 0 || rd_b[k] < 0 || seen[rd_a[k]] || seen[rd_b[k]] || rd_a[k] == rd_b[k]) begin
            perm_err++;
          end else begin
            seen[rd_a[k]] = 1'b1;
            seen[rd_b[k]] = 1'b1;
          end
        end
      end
      chk("wr_follows_rd", dly_err, 0);
      chk("layer_gap", gap_err, 0);
      chk("layer_permutation", perm_err, 0);
    end
  endtask

  task automatic check_vectors(input logic m);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].m == m) begin
        int idx;
        idx = vecs[i].layer * 128 + vecs[i].bf;
        chk($sformatf("vec%0d_a", i), rd_a[idx], vecs[i].a);
        chk($sformatf("vec%0d_b", i), rd_b[idx], vecs[i].b);
        chk($sformatf("vec%0d_tw", i), rd_tw[idx], vecs[i].tw);
        chk($sformatf("vec%0d_cyc", i), rd_cyc[idx], 1 + 134 * vecs[i].layer + vecs[i].bf);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 0,   0,   0, 128,   1};
    vecs[1] = '{1'b0, 0, 127, 127, 255,   1};
    vecs[2] = '{1'b0, 1,   0,   0,  64,   2};
    vecs[3] = '{1'b0, 1,  64, 128, 192,   3};
    vecs[4] = '{1'b0, 6,   0,   0,   2,  64};
    vecs[5] = '{1'b0, 6, 127, 253, 255, 127};
    vecs[6] = '{1'b1, 0,   0,   0,   2, 127};
    vecs[7] = '{1'b1, 0,   1,   1,   3, 127};
    vecs[8] = '{1'b1, 0,   2,   4,   6, 126};
    vecs[9] = '{1'b1, 6,   0,   0, 128,   1};

    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 1'b0);
    check_vectors(1'b0);

    // INTT run with start/mode poked mid-run: must be ignored
    run(1'b1, 1'b1);
    check_vectors(1'b1);

    // Reset in cycle 300 of an NTT run: outputs clear, no late writes
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) @(negedge clk);
    chk("pre_rst_wr_en", int'(wr_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("midrst");
    begin
      int late;
      late = 0;
      for (int c = 0; c < 20; c++) begin
        if (wr_en || rd_en || busy) late++;
        @(negedge clk);
      end
      chk("post_rst_activity", late, 0);
    end

    run(1'b0, 1'b0);
    check_vectors(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
